// File: rtl/sm4_round_ctrl.sv
// sm4_round_ctrl: iterative SM4 round controller.
// Runs the 32 SM4 rounds on one 128-bit block at a time. Each round is
// issued to an external T-transform pipeline of T_LAT register stages and
// uses a round key fetched combinationally from an external key buffer.
//
// Parameters:
//   WORD_WIDTH - width of one SM4 word and of the T-transform datapath
//   T_LAT      - register latency of the T-transform, 1..7
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid/in_ready     - block input handshake; in_data = {X0,X1,X2,X3}
//   in_decrypt            - 1 = decrypt (round keys used in reverse order)
//   rk_idx/rk_data        - round-key request, key returned the same cycle
//   t_data_in/t_stall     - operand and stall to the T-transform pipeline
//   t_data_out            - T-transform result
//   out_valid/out_ready   - result handshake; out_data = {X35,X34,X33,X32}
//   busy                  - high whenever the controller is not idle
//   blk_cnt               - completed-block counter, present only when
//                           SM4_BLK_CNT_EN is defined
module sm4_round_ctrl #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned T_LAT      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_decrypt,
  input  logic [4*WORD_WIDTH-1:0] in_data,
  output logic [4:0]              rk_idx,
  input  logic [WORD_WIDTH-1:0]   rk_data,
  output logic [WORD_WIDTH-1:0]   t_data_in,
  output logic                    t_stall,
  input  logic [WORD_WIDTH-1:0]   t_data_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*WORD_WIDTH-1:0] out_data,
  output logic                    busy
`ifdef SM4_BLK_CNT_EN
  ,
  output logic [15:0]             blk_cnt
`endif
);

  localparam int unsigned BLK_W = 4 * WORD_WIDTH;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned RND_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t                state;
  logic [RND_W-1:0]      round;
  logic [RND_W-1:0]      round_inc;
  logic [CNT_W-1:0]      wait_cnt;
  logic [WORD_WIDTH-1:0] x0;
  logic [WORD_WIDTH-1:0] x1;
  logic [WORD_WIDTH-1:0] x2;
  logic [WORD_WIDTH-1:0] x3;
  logic [WORD_WIDTH-1:0] x_new;
  logic                  mode_dec;

  assign round_inc = round + RND_W'(1);
  assign x_new     = x0 ^ t_data_out;

  // Round operand is only presented in ISSUE; the key arrives combinationally.
  assign t_data_in = (state == ISSUE) ? (x1 ^ x2 ^ x3 ^ rk_data) : '0;

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round     <= '0;
      wait_cnt  <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      x3        <= '0;
      mode_dec  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      t_stall   <= 1'b1;
      rk_idx    <= '0;
      out_data  <= '0;
`ifdef SM4_BLK_CNT_EN
      blk_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            x0       <= in_data[BLK_W-1 -: WORD_WIDTH];
            x1       <= in_data[3*WORD_WIDTH-1 -: WORD_WIDTH];
            x2       <= in_data[2*WORD_WIDTH-1 -: WORD_WIDTH];
            x3       <= in_data[WORD_WIDTH-1 -: WORD_WIDTH];
            mode_dec <= in_decrypt;
            round    <= '0;
            wait_cnt <= '0;
            // 31 - 0 in decrypt mode is all ones.
            rk_idx   <= in_decrypt ? RND_W'(31) : RND_W'(0);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            t_stall  <= 1'b0;
            state    <= ISSUE;
          end
        end

        ISSUE: begin
          wait_cnt <= CNT_W'(1);
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == CNT_W'(T_LAT)) begin
            // T-transform result for this round is on t_data_out now.
            x0       <= x1;
            x1       <= x2;
            x2       <= x3;
            x3       <= x_new;
            wait_cnt <= '0;
            if (round == RND_W'(31)) begin
              out_data  <= {x_new, x3, x2, x1};
              out_valid <= 1'b1;
              t_stall   <= 1'b1;
              state     <= DONE;
            end else begin
              round  <= round_inc;
              // 31 - r for a 5-bit index is its bitwise complement.
              rk_idx <= mode_dec ? ~round_inc : round_inc;
              state  <= ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef SM4_BLK_CNT_EN
            blk_cnt   <= blk_cnt + 16'd1;
`endif
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// tb_sm4_round_ctrl: directed bench for sm4_round_ctrl.
// Provides an SM4 key-schedule table behind rk_idx and a T_LAT-stage
// T-transform pipeline model, then checks results against the standard
// SM4 test vector and the handshake/reset behaviour.
module tb_sm4_round_ctrl;

  localparam int unsigned WW      = 32;
  localparam int unsigned T_LAT   = 2;
  localparam int          LAT_EXP = 32 * (T_LAT + 1) + 1;

  localparam logic [127:0] KEY_C = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT_C  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT_C  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] FK_C  = 128'ha3b1bac656aa3350677d9197b27022dc;

  localparam logic [2047:0] SBOX_TBL = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_decrypt;
  logic [4*WW-1:0]  in_data;
  logic [4:0]       rk_idx;
  logic [WW-1:0]    rk_data;
  logic [WW-1:0]    t_data_in;
  logic             t_stall;
  logic [WW-1:0]    t_data_out;
  logic             out_valid;
  logic             out_ready;
  logic [4*WW-1:0]  out_data;
  logic             busy;
`ifdef SM4_BLK_CNT_EN
  logic [15:0]      blk_cnt;
`endif

  logic [WW-1:0]    rk_tab [32];
  logic [WW-1:0]    tpipe  [T_LAT];

  int n_vec = 0;
  int n_err = 0;

  sm4_round_ctrl #(
    .WORD_WIDTH (WW),
    .T_LAT      (T_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_decrypt (in_decrypt),
    .in_data    (in_data),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data),
    .t_data_in  (t_data_in),
    .t_stall    (t_stall),
    .t_data_out (t_data_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
`ifdef SM4_BLK_CNT_EN
    ,
    .blk_cnt    (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [2047:0] tbl;
    tbl = SBOX_TBL;
    return tbl[2047 - 8 * int'(a) -: 8];
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox(a[8*j +: 8]);
    return b;
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = tau(a);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  function automatic logic [31:0] ck_word(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[31 - 8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
    return w;
  endfunction

  // Key buffer: round key returned in the same cycle as the index.
  assign rk_data = rk_tab[rk_idx];

  // T-transform pipeline of T_LAT stages, frozen while stalled.
  always @(posedge clk) begin
    if (!t_stall) begin
      tpipe[0] <= t_enc(t_data_in);
      for (int i = 1; i < T_LAT; i++) tpipe[i] <= tpipe[i-1];
    end
  end
  assign t_data_out = tpipe[T_LAT-1];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_in_ready"},  160'(in_ready),  160'(1'b1));
    chk({pfx, "_out_valid"}, 160'(out_valid), 160'(1'b0));
    chk({pfx, "_busy"},      160'(busy),      160'(1'b0));
    chk({pfx, "_t_stall"},   160'(t_stall),   160'(1'b1));
    chk({pfx, "_rk_idx"},    160'(rk_idx),    160'(5'd0));
    chk({pfx, "_out_data"},  160'(out_data),  160'(128'd0));
  endtask

  // Offer one block, then wait (bounded) for out_valid. Returns at the
  // negedge where out_valid is first seen; lat counts cycles after accept.
  task automatic run_block(input logic [127:0] din, input logic dec, input bit noise,
                           output int lat, output logic [159:0] rk_seq);
    int cyc;
    chk("accept_in_ready", 160'(in_ready), 160'(1'b1));
    in_data    = din;
    in_decrypt = dec;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc      = 1;
    lat      = -1;
    rk_seq   = '0;
    while (lat < 0 && cyc <= 400) begin
      if (out_valid) begin
        lat = cyc;
      end else begin
        if (((cyc - 1) % (T_LAT + 1)) == 0 && cyc <= 32 * (T_LAT + 1))
          rk_seq = {rk_seq[154:0], rk_idx};
        if (noise) begin
          in_valid   = 1'($urandom_range(0, 1));
          in_decrypt = 1'($urandom_range(0, 1));
          in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0;
    if (lat < 0) chk("out_valid_timeout", 160'(1'b0), 160'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  kk [36];
    logic [127:0] key_v;
    logic [127:0] fk_v;
    logic [159:0] rk_seq;
    logic [159:0] rk_exp;
    int           lat;
    bit           hold_ok;
    bit           ov_seen;

    key_v = KEY_C;
    fk_v  = FK_C;
    for (int i = 0; i < 4; i++) kk[i] = key_v[127 - 32*i -: 32] ^ fk_v[127 - 32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      kk[i+4]   = kk[i] ^ t_key(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck_word(i));
      rk_tab[i] = kk[i+4];
    end
    for (int i = 0; i < T_LAT; i++) tpipe[i] = '0;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_decrypt = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
`ifdef SM4_BLK_CNT_EN
    chk("reset_blk_cnt", 160'(blk_cnt), 160'(16'd0));
`endif
    rst = 1'b0;
    @(negedge clk);

    // Encrypt with backpressure.
    run_block(PT_C, 1'b0, 1'b0, lat, rk_seq);
    chk("enc_latency", 160'(lat), 160'(LAT_EXP));
    chk("enc_data", 160'(out_data), 160'(CT_C));
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_data !== CT_C || in_ready !== 1'b0 || t_stall !== 1'b1 || out_valid !== 1'b1)
        hold_ok = 1'b0;
    end
    chk("bp_hold_stable", 160'(hold_ok), 160'(1'b1));
    out_ready = 1'b1;
    chk("bp_handshake_in_ready", 160'(in_ready), 160'(1'b0));
    @(negedge clk);
    chk("bp_release_in_ready", 160'(in_ready), 160'(1'b1));
    chk("bp_release_out_valid", 160'(out_valid), 160'(1'b0));
    chk("bp_release_busy", 160'(busy), 160'(1'b0));
    chk("bp_release_t_stall", 160'(t_stall), 160'(1'b1));

    // Decrypt with out_ready held high; check reversed key order.
    run_block(CT_C, 1'b1, 1'b0, lat, rk_seq);
    rk_exp = '0;
    for (int r = 0; r < 32; r++) rk_exp = {rk_exp[154:0], 5'(31 - r)};
    chk("dec_latency", 160'(lat), 160'(LAT_EXP));
    chk("dec_data", 160'(out_data), 160'(PT_C));
    chk("dec_rk_seq", rk_seq, rk_exp);
    @(negedge clk);
    chk("done_one_cycle_out_valid", 160'(out_valid), 160'(1'b0));
    chk("done_one_cycle_in_ready", 160'(in_ready), 160'(1'b1));

    // Random input activity while busy must not disturb the block.
    run_block(PT_C, 1'b0, 1'b1, lat, rk_seq);
    chk("noise_latency", 160'(lat), 160'(LAT_EXP));
    chk("noise_data", 160'(out_data), 160'(CT_C));
    @(negedge clk);
    chk("noise_idle_in_ready", 160'(in_ready), 160'(1'b1));

    // Reset pulse in round 10 of a block.
    in_data    = PT_C;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10 * (T_LAT + 1)) @(negedge clk);
    chk("mid_rk_idx_round10", 160'(rk_idx), 160'(5'd10));
    chk("mid_busy", 160'(busy), 160'(1'b1));
    chk("mid_t_stall", 160'(t_stall), 160'(1'b0));
    chk("mid_in_ready", 160'(in_ready), 160'(1'b0));
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst     = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < LAT_EXP + 10; i++) begin
      @(negedge clk);
      ov_seen = ov_seen | out_valid;
    end
    chk("midrst_no_out_valid", 160'(ov_seen), 160'(1'b0));
    run_block(CT_C, 1'b1, 1'b0, lat, rk_seq);
    chk("post_rst_latency", 160'(lat), 160'(LAT_EXP));
    chk("post_rst_data", 160'(out_data), 160'(PT_C));
    @(negedge clk);

`ifdef SM4_BLK_CNT_EN
    force dut.blk_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt;
    run_block(PT_C, 1'b0, 1'b0, lat, rk_seq);
    chk("cnt_block_data", 160'(out_data), 160'(CT_C));
    @(negedge clk);
    chk("cnt_wrap", 160'(blk_cnt), 160'(16'h0000));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sm4_round_ctrl.md
SM4_ROUND_CTRL -- requirements
Module: sm4_round_ctrl

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, width of one SM4 word and of the T-transform datapath.
REQ-002 SHALL have parameter T_LAT, default 2, register latency of the attached T-transform, legal range 1..7.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  a block is offered on in_data.
REQ-006 SHALL have port in_ready  output  1  controller can accept a block.
REQ-007 SHALL have port in_decrypt  input  1  mode of the offered block: 1 = decrypt, 0 = encrypt.
REQ-008 SHALL have port in_data  input  4*WORD_WIDTH  block {X0,X1,X2,X3}; X0 in the MSBs.
REQ-009 SHALL have port rk_idx  output  5  round-key index requested from the key buffer.
REQ-010 SHALL have port rk_data  input  WORD_WIDTH  round key for rk_idx, valid in the same cycle.
REQ-011 SHALL have port t_data_in  output  WORD_WIDTH  operand to the T-transform pipeline.
REQ-012 SHALL have port t_stall  output  1  stall to the T-transform pipeline.
REQ-013 SHALL have port t_data_out  input  WORD_WIDTH  T-transform result.
REQ-014 SHALL have port out_valid  output  1  result block is valid on out_data.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the result block.
REQ-016 SHALL have port out_data  output  4*WORD_WIDTH  result {X35,X34,X33,X32}; X35 in the MSBs.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE; on in_valid&in_ready it latches X0..X3 and the mode, clears round to 0, and enters ISSUE.
REQ-020 In ISSUE, SHALL drive t_data_in = X1^X2^X3^rk_data, drive t_stall=0, and go to WAIT with wait count 1.
REQ-021 Outside ISSUE, SHALL drive t_data_in = 0.
REQ-022 SHALL drive rk_idx = round in encrypt mode and 31-round in decrypt mode, stable in every state except IDLE.
REQ-023 In WAIT, SHALL keep t_stall=0 and increment the wait count each cycle.
REQ-024 In the WAIT cycle where the count equals T_LAT, SHALL shift {X0,X1,X2,X3} <= {X1,X2,X3,X0^t_data_out}.
REQ-025 After that shift, SHALL go to ISSUE with round+1, or to DONE if round was 31.
REQ-026 Each round SHALL take exactly T_LAT+1 cycles; accept-to-out_valid latency SHALL be 32*(T_LAT+1)+1 cycles (97 at T_LAT=2).
REQ-027 In DONE, SHALL assert out_valid and hold out_data stable until out_ready; the handshake cycle returns to IDLE.
REQ-028 in_ready SHALL first reassert in the cycle after the out_valid&out_ready handshake (no same-cycle back-to-back accept).
REQ-029 In IDLE and DONE, SHALL hold t_stall=1.
REQ-030 in_valid while busy SHALL be ignored; in_data and in_decrypt changes while busy SHALL NOT affect the block in flight.
REQ-031 SHALL be able to leave out_ready asserted permanently; DONE then lasts exactly one cycle.

Reset
REQ-032 While rst=1, SHALL force state=IDLE, round=0, wait count=0, X0..X3=0, in_ready=1, out_valid=0, busy=0, t_stall=1, rk_idx=0 and out_data=0.
REQ-033 rst asserted in ISSUE, WAIT or DONE SHALL discard the block in flight, with no out_valid pulse.

Configuration
REQ-034 With macro SM4_BLK_CNT_EN defined, SHALL add port blk_cnt  output  16, reset to 0, incremented on each out_valid&out_ready, wrapping from 0xFFFF to 0.
REQ-035 Without SM4_BLK_CNT_EN, the blk_cnt port and its counter SHALL be absent, with otherwise identical behaviour.

Verification
REQ-036 Encrypt: with key 0123456789abcdeffedcba9876543210 rk model, encrypting plaintext 0123456789abcdeffedcba9876543210 SHALL give out_data=681edf34d206965e86b3e94f536e4246, with out_valid exactly 97 cycles after accept.
REQ-037 Decrypt: in_decrypt=1 on ciphertext 681edf34d206965e86b3e94f536e4246 SHALL give 0123456789abcdeffedcba9876543210, and rk_idx SHALL sequence 31 down to 0.
REQ-038 Backpressure: out_ready held 0 for 20 cycles after out_valid SHALL keep out_data stable, in_ready=0 and t_stall=1; releasing it SHALL raise in_ready next cycle.
REQ-039 Mid-operation reset: rst pulsed at round 10 SHALL give all REQ-032 values next cycle; a following block SHALL then complete correctly.
REQ-040 Ignored input: in_valid toggled with random data during a busy block SHALL leave the result and its latency unchanged.
REQ-041 Counter wrap (SM4_BLK_CNT_EN defined): blk_cnt preloaded to 0xFFFF by a force, then one completed block, SHALL read 0x0000.
